text_overlay_gen: RTL

TEXT_OVERLAY_GEN -- requirements
Module: text_overlay_gen

---
 rtl/text_overlay_pkg.sv | 16 +
 rtl/font_rom.sv | 32 +++
 rtl/text_overlay_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay generator.
// Blink support is enabled by defining TEXT_OVERLAY_BLINK_EN.
package text_overlay_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int FONT_ADDR_W = 11;

  typedef struct packed {
    logic       blink;
    logic [6:0] code;
  } cell_t;

  localparam logic [7:0] COLOR_BG = 8'h00;

endpackage

// File: rtl/font_rom.sv
// 8x16 glyph ROM, one registered read per cycle.
// Reduced glyph set: 'A' and 'B'; every other code reads as blank.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  localparam logic [127:0] GLYPH_A =
    128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
  localparam logic [127:0] GLYPH_B =
    128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;

  logic [127:0] glyph;
  logic [127:0] shifted;

  always_comb begin
    glyph = '0;
    unique case (addr_i[10:4])
      7'h41:   glyph = GLYPH_A;
      7'h42:   glyph = GLYPH_B;
      default: glyph = '0;
    endcase
    // line 0 sits in the top byte
    shifted = glyph >> {(4'd15 - addr_i[3:0]), 3'b000};
  end

  always_ff @(posedge clk) begin
    data_o <= shifted[7:0];
  end

endmodule

// File: rtl/text_overlay_gen.sv
// Character-cell text overlay: text buffer -> font ROM -> pixel, 3 cycles.
// Define TEXT_OVERLAY_BLINK_EN to blank blink-attributed cells on a frame counter.
module text_overlay_gen
  import text_overlay_pkg::*;
#(
  parameter int         COLS       = 16,
  parameter int         ROWS       = 4,
  parameter int         SCALE_LOG2 = 1,
  parameter int         X0         = 64,
  parameter int         Y0         = 128,
  parameter logic [7:0] FG_COLOR   = 8'hFF,
  parameter int         BLINK_LOG2 = 5,
  localparam int        NCELLS     = COLS * ROWS,
  localparam int        AW         = $clog2(NCELLS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          text_on,
  output logic [7:0]    rgb_text
);

  localparam int X_END = X0 + COLS * CHAR_W * (1 << SCALE_LOG2);
  localparam int Y_END = Y0 + ROWS * CHAR_H * (1 << SCALE_LOG2);

  cell_t mem [NCELLS];

  logic [9:0]    dx, dy, col, row;
  logic          region_s0;
  logic [AW-1:0] idx_s0;
  logic [2:0]    bit_s0;
  logic [3:0]    line_s0;

  assign dx = pixel_x - 10'(X0);
  assign dy = pixel_y - 10'(Y0);
  assign col = dx >> (3 + SCALE_LOG2);
  assign row = dy >> (4 + SCALE_LOG2);
  assign bit_s0 = 3'(dx >> SCALE_LOG2);
  assign line_s0 = 4'(dy >> SCALE_LOG2);

  assign region_s0 = (32'(pixel_x) >= 32'(X0))
                  && (32'(pixel_x) < 32'(X_END))
                  && (32'(pixel_y) >= 32'(Y0))
                  && (32'(pixel_y) < 32'(Y_END));

  // out-of-region pixels read cell 0 so the index never leaves the array
  assign idx_s0 = region_s0
    ? AW'(32'(row) * 32'(COLS) + 32'(col))
    : '0;

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < 32'(NCELLS)))
      mem[wr_addr] <= cell_t'(wr_data);
  end

  cell_t      cell_q;
  logic       vid1_q, reg1_q;
  logic [2:0] bit1_q;
  logic [3:0] line1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_q  <= '0;
      vid1_q  <= 1'b0;
      reg1_q  <= 1'b0;
      bit1_q  <= '0;
      line1_q <= '0;
    end else begin
      cell_q  <= mem[idx_s0];
      vid1_q  <= video_on;
      reg1_q  <= region_s0;
      bit1_q  <= bit_s0;
      line1_q <= line_s0;
    end
  end

  logic show_s1;

`ifdef TEXT_OVERLAY_BLINK_EN
  logic                  tick_q;
  logic [BLINK_LOG2-1:0] cnt_q, cnt_d;

  assign cnt_d = tick_q ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      tick_q <= (pixel_x == 10'd0) && (pixel_y == 10'd0);
      cnt_q  <= cnt_d;
    end
  end

  assign show_s1 = !(cell_q.blink && cnt_q[BLINK_LOG2-1]);
`else
  logic unused_blink;
  assign unused_blink = cell_q.blink;
  assign show_s1 = 1'b1;
`endif

  logic [7:0] font_data;

  font_rom u_font (
    .clk    (clk),
    .addr_i ({cell_q.code, line1_q}),
    .data_o (font_data)
  );

  logic       vid2_q, reg2_q, show2_q;
  logic [2:0] bit2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid2_q  <= 1'b0;
      reg2_q  <= 1'b0;
      show2_q <= 1'b0;
      bit2_q  <= '0;
    end else begin
      vid2_q  <= vid1_q;
      reg2_q  <= reg1_q;
      show2_q <= show_s1;
      bit2_q  <= bit1_q;
    end
  end

  logic on_d;
  logic text_on_q;
  logic [7:0] rgb_q;

  assign on_d = vid2_q && reg2_q && show2_q
             && font_data[3'd7 - bit2_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      text_on_q <= 1'b0;
      rgb_q     <= COLOR_BG;
    end else begin
      text_on_q <= on_d;
      rgb_q     <= on_d ? FG_COLOR : COLOR_BG;
    end
  end

  assign text_on  = text_on_q;
  assign rgb_text = rgb_q;

endmodule
